// File: rtl/n64_pkg.sv
// Shared N64 line-protocol definitions for the controller transmitter and receiver.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package n64_pkg;

  // Symbol timing in microseconds. A data bit is one 4 us cell. Its low phase is
  // SHORT_US for a '1' and LONG_US for a '0'. Stop bits are a bare low pulse.
  localparam int BIT_US          = 4;
  localparam int SHORT_US        = 1;
  localparam int LONG_US         = 3;
  localparam int CTRL_STOP_US    = 2;
  localparam int CONSOLE_STOP_US = 1;

  // Response transmitter states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_BIT,
    ST_STOP
  } tx_state_e;

  // Standard controller status response: id 0x0500, no pak inserted.
  localparam logic [7:0] RESP_STATUS_0 = 8'h05;
  localparam logic [7:0] RESP_STATUS_1 = 8'h00;
  localparam logic [7:0] RESP_STATUS_2 = 8'h02;

  // Counter width for a counter that must hold the values 0..n-1. It never returns 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n64_bit_encoder.sv
// Pulse-width encodes one N64 symbol (data bit or controller stop bit) onto data_oe.
// Latency: data_oe goes high on the edge after go; end_of_symbol flags the final cycle of the symbol.
// Backpressure: none; a go in the end_of_symbol cycle chains the next symbol with no idle cycle.
//
// Ports:
//   sample_clk, reset  clock and async active-high reset
//   go                 start a new symbol on the next edge
//   bit_val            data bit to send (ignored when stop=1)
//   stop               send a controller stop bit instead of a data bit
//   data_oe            1 = pull the line low
//   end_of_symbol      high during the last cycle of the current symbol
module n64_bit_encoder
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US = 4
)(
  input  logic sample_clk,
  input  logic reset,
  input  logic go,
  input  logic bit_val,
  input  logic stop,
  output logic data_oe,
  output logic end_of_symbol
);

  localparam int BIT_CYC = BIT_US * CLKS_PER_US;
  localparam int CNT_W   = cnt_width(BIT_CYC);

  // The lengths use one extra bit so that a full-cell count, and cnt+1, do not wrap.
  localparam logic [CNT_W:0] SHORT_CYC = (CNT_W+1)'(SHORT_US * CLKS_PER_US);
  localparam logic [CNT_W:0] LONG_CYC  = (CNT_W+1)'(LONG_US * CLKS_PER_US);
  localparam logic [CNT_W:0] STOP_CYC  = (CNT_W+1)'(CTRL_STOP_US * CLKS_PER_US);
  localparam logic [CNT_W:0] BIT_LAST  = (CNT_W+1)'(BIT_CYC - 1);
  localparam logic [CNT_W:0] STOP_LAST = (CNT_W+1)'(CTRL_STOP_US * CLKS_PER_US - 1);
  localparam logic [CNT_W:0] EXT_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             active_q;
  logic             bit_q;
  logic             stop_q;
  logic             oe_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   low_len;
  logic [CNT_W:0]   sym_last;
  logic             oe_next;

  always_comb begin
    cnt_ext = {1'b0, cnt_q};
    if (stop_q) begin
      low_len  = STOP_CYC;
      sym_last = STOP_LAST;
    end else begin
      low_len  = bit_q ? SHORT_CYC : LONG_CYC;
      sym_last = BIT_LAST;
    end
    end_of_symbol = active_q && (cnt_ext == sym_last);
  end

  // data_oe is registered so the open-drain enable cannot glitch on counter decode.
  // oe_next is therefore the value the line will take in the cycle after this one.
  always_comb begin
    if (go) begin
      oe_next = 1'b1;                        // every symbol opens with its low phase
    end else if (!active_q || end_of_symbol) begin
      oe_next = 1'b0;
    end else begin
      oe_next = (cnt_ext + EXT_ONE) < low_len;
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      stop_q   <= 1'b0;
      oe_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      oe_q <= oe_next;
      if (go) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
        bit_q    <= bit_val;
        stop_q   <= stop;
      end else if (end_of_symbol) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else if (active_q) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign data_oe = oe_q;

endmodule

// File: rtl/n64_response_tx.sv
// Serializes controller response bytes MSB first onto the open-drain N64 line, then sends the stop bit.
// Latency: first falling edge TURNAROUND_US*CLKS_PER_US cycles after start; 4 us per bit and 2 us for the stop bit.
// Backpressure: byte stream is valid/ready; a missing byte at a byte boundary ends the response with underrun.
//
// Ports:
//   sample_clk, reset   4 MHz sample clock and async active-high reset
//   start               one-cycle request from the command decoder; ignored while busy or on done
//   byte_data/_valid/_last, byte_ready   response byte stream from the response builder
//   data_oe             1 = drive the line low
//   busy                response in progress
//   done, underrun      one-cycle end-of-response pulse; underrun qualifies done
module n64_response_tx
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US   = 4,
  parameter int TURNAROUND_US = 2
)(
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       data_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int TURN_CYC = TURNAROUND_US * CLKS_PER_US;
  localparam int TURN_W   = cnt_width(TURN_CYC);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);

  tx_state_e         state_q, state_n;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_n;
  logic [7:0]        shift_q, shift_n;
  logic              last_q, last_n;       // held byte is the final byte
  logic              held_q, held_n;       // a byte has been accepted during TURN
  logic [2:0]        bit_idx_q, bit_idx_n; // index of the bit currently on the line
  logic              starve_q, starve_n;   // the response is ending because of a starved stream
  logic              done_q, done_n;
  logic              underrun_q, underrun_n;

  logic              enc_go;
  logic              enc_bit;
  logic              enc_stop;
  logic              enc_eos;
  logic [7:0]        cur_byte;
  logic              turn_fire;

  n64_bit_encoder #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_enc (
    .sample_clk    (sample_clk),
    .reset         (reset),
    .go            (enc_go),
    .bit_val       (enc_bit),
    .stop          (enc_stop),
    .data_oe       (data_oe),
    .end_of_symbol (enc_eos)
  );

  always_comb begin
    state_n    = state_q;
    turn_cnt_n = turn_cnt_q;
    shift_n    = shift_q;
    last_n     = last_q;
    held_n     = held_q;
    bit_idx_n  = bit_idx_q;
    starve_n   = starve_q;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    enc_go     = 1'b0;
    enc_bit    = 1'b0;
    enc_stop   = 1'b0;
    byte_ready = 1'b0;
    cur_byte   = shift_q;
    turn_fire  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_q high means this is the done cycle, in which start is ignored.
        if (start && !done_q) begin
          state_n    = ST_TURN;
          turn_cnt_n = '0;
          held_n     = 1'b0;
          starve_n   = 1'b0;
        end
      end

      ST_TURN: begin
        byte_ready = !held_q;
        turn_fire  = byte_valid && !held_q;
        if (turn_fire) begin
          shift_n = byte_data;
          last_n  = byte_last;
          held_n  = 1'b1;
        end
        if (turn_cnt_q == TURN_LAST) begin
          // A byte accepted in this final cycle still counts as held.
          if (held_q || turn_fire) begin
            cur_byte  = turn_fire ? byte_data : shift_q;
            enc_go    = 1'b1;
            enc_bit   = cur_byte[7];
            shift_n   = {cur_byte[6:0], 1'b0};
            bit_idx_n = 3'd0;
            state_n   = ST_BIT;
          end else begin
            done_n     = 1'b1;
            underrun_n = 1'b1;
            state_n    = ST_IDLE;
          end
        end else begin
          turn_cnt_n = turn_cnt_q + TURN_ONE;
        end
      end

      ST_BIT: begin
        if (enc_eos) begin
          if (bit_idx_q != 3'd7) begin
            enc_go    = 1'b1;
            enc_bit   = shift_q[7];
            shift_n   = {shift_q[6:0], 1'b0};
            bit_idx_n = bit_idx_q + 3'd1;
          end else begin
            // Byte boundary: the only cycle in which the next byte may be taken.
            byte_ready = !last_q;
            if (!last_q && byte_valid) begin
              enc_go    = 1'b1;
              enc_bit   = byte_data[7];
              shift_n   = {byte_data[6:0], 1'b0};
              last_n    = byte_last;
              bit_idx_n = bit_idx_q + 3'd1;   // wraps 7 -> 0
            end else begin
              enc_go   = 1'b1;
              enc_stop = 1'b1;
              starve_n = !last_q;
              state_n  = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        if (enc_eos) begin
          done_n     = 1'b1;
          underrun_n = starve_q;
          state_n    = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      turn_cnt_q <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      held_q     <= 1'b0;
      bit_idx_q  <= '0;
      starve_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      turn_cnt_q <= turn_cnt_n;
      shift_q    <= shift_n;
      last_q     <= last_n;
      held_q     <= held_n;
      bit_idx_q  <= bit_idx_n;
      starve_q   <= starve_n;
      done_q     <= done_n;
      underrun_q <= underrun_n;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: doc/n64_response_tx.md
Name: n64_response_tx

Overview:
- Transmit side of the fake N64 controller: serializes the controller's response bytes onto the single-wire, open-drain N64 data line.
- Runs on the same 4 MHz sample_clk domain that samples the console command.
- Triggered by the command decoder after the console stop bit. Pulls a byte stream from the response builder and encodes it MSB first with N64 pulse-width coding, followed by the controller stop bit.

Parameters:
- CLKS_PER_US, 4, sample_clk cycles per microsecond; one timing unit "U".
- TURNAROUND_US, 2, microseconds from start to the first falling edge.

Ports:
- sample_clk  in  1  system clock, 4 MHz
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request to begin a response; ignored while busy
- byte_data  in  8  next response byte
- byte_valid  in  1  byte_data/byte_last valid
- byte_last  in  1  qualifies byte_data as the final byte
- byte_ready  out  1  byte accepted on the cycle byte_valid && byte_ready
- data_oe  out  1  1 = drive line low; 0 = release (pull-up gives high)
- busy  out  1  response in progress
- done  out  1  one-cycle pulse at the end of a response
- underrun  out  1  valid only with done; 1 = byte stream starved

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, counters and shift register cleared. If reset arrives mid-bit, data_oe must fall to 0 immediately; no partial stop bit is sent.
- States: IDLE, TURN, BIT, STOP.
- IDLE:
  - start=1 at edge k moves the FSM to TURN; busy=1 from edge k.
- TURN:
  - Lasts TURNAROUND_US*CLKS_PER_US cycles.
  - byte_ready=1 while no byte is held. The first accepted byte is loaded into the shift register along with its last flag.
  - At the end of TURN with a byte held: enter BIT, and data_oe=1 from edge k+TURNAROUND_US*CLKS_PER_US.
  - At the end of TURN with no byte held: done=1 and underrun=1 for one cycle, busy=0, back to IDLE. The line is never driven.
- BIT:
  - Each bit lasts 4U = 4*CLKS_PER_US cycles, MSB first.
  - Bit '0': data_oe=1 for 3U, then 0 for 1U.
  - Bit '1': data_oe=1 for 1U, then 0 for 3U.
  - byte_ready pulses for exactly one cycle, the final cycle of the 8th bit, and only if the held byte is not last.
  - If byte_valid is high in that cycle, the next byte loads and the next bit starts on the following cycle with no gap.
  - If byte_valid is low in that cycle, go to STOP and flag underrun.
  - If the held byte was last, go to STOP; byte_ready stays 0.
- STOP:
  - data_oe=1 for 2U (controller stop bit), then release.
  - The cycle after the last low cycle: done=1 (plus underrun if flagged), busy=0, back to IDLE.
- Byte count is unbounded; the last flag or an underrun ends the response.
- Simultaneous events:
  - start during busy is ignored.
  - start in the same cycle as the done pulse is ignored; start is accepted from the next cycle.
  - byte_valid outside byte_ready is ignored; the producer holds data.
- Counters: the unit counter is sized clog2(4*CLKS_PER_US); the bit index is 3 bits and wraps 7 to 0 on a byte load.
- 4-byte response with CLKS_PER_US=4: 32*16 + 8 = 520 cycles from first fall to release.

Decomposition:
- Shared package n64_pkg holds:
  - constants BIT_US=4, SHORT_US=1, LONG_US=3, CTRL_STOP_US=2, CONSOLE_STOP_US=1
  - FSM state typedef
  - standard response byte constants (status 0x05 0x00 0x02). The receiver reuses the same package.
- Sub-module n64_bit_encoder:
  - Inputs: go, bit value, stop flag.
  - Outputs: data_oe and end_of_symbol.
  - Owns the per-symbol unit counter.
  - The parent FSM handles the byte handshake and shifting.

Test Plan:
- start, then bytes 0x80,0x00,0x00,0x00(last) presented immediately -> first fall 8 cycles after start; bit0 low 4/high 12, the other 31 bits low 12/high 4; stop low 8; done=1, underrun=0 at cycle 8+520 after start; byte_ready seen 4 times.
- Status response 0x05,0x00,0x02(last) -> decoded via async_to_sync the line reads 0x05 0x00 0x02 plus stop; 3 byte_ready acceptances; 392 cycles from first fall to release.
- 2 bytes, second byte_valid withheld at the 8th-bit final cycle -> after 8 bits the stop bit follows directly; done=1 with underrun=1; a late byte is not accepted.
- start with byte_valid=0 throughout TURN -> data_oe stays 0; done=1 with underrun=1 at cycle 8; busy=0 afterwards.
- Reset asserted mid-low-phase of bit 5 -> data_oe=0 asynchronously; all outputs 0; a subsequent start transmits normally from bit 0.
- start pulsed during busy and coincident with done -> no effect on the waveform; a second start one cycle after done begins a new TURN.
